// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer for the single-port data RAM.
// Requester 0 is the CPU load/store unit, requester 1 the DMA/debug loader.
// Each transaction takes IDLE (arbitrate/latch) -> ACCESS (RAM pins) -> DONE (ACK).
// Optional macro RAM_ARB_RANGE_CHECK_EN: out-of-window or misaligned addresses
// are not forwarded to the RAM and complete with ERR = 1.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request; winner picked and latched on the edge
// ST_ACCESS | RAM CE/RD/WR/ADDR/WDATA driven for exactly one cycle
// ST_DONE   | ACK/ERR/RDATA presented to the granted requester for one cycle
module ram_arbiter #(
    parameter int unsigned ARB_MODE   = 0,
    parameter logic [31:0] RAM_ORIGIN = 32'h100,
    parameter logic [31:0] RAM_LENGTH = 32'h08000
) (
    input  logic        iRAM_CLK,
    input  logic        iRAM_RST,
    input  logic        iM0_REQ,
    input  logic        iM0_WE,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_WDATA,
    output logic        oM0_ACK,
    output logic [31:0] oM0_RDATA,
    output logic        oM0_ERR,
    input  logic        iM1_REQ,
    input  logic        iM1_WE,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_WDATA,
    output logic        oM1_ACK,
    output logic [31:0] oM1_RDATA,
    output logic        oM1_ERR,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [31:0] oRAM_ADDR,
    output logic [31:0] oRAM_WDATA,
    input  logic [31:0] iRAM_RDATA,
    output logic [1:0]  oGNT,
    output logic        oBUSY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state;
    logic        last_gnt;   // 1 = requester 1 was granted last
    logic        lat_bad;    // latched transaction failed the window check
    logic [1:0]  gnt;
    logic        busy;
    logic        ram_ce;
    logic        ram_rd;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        m0_ack;
    logic        m1_ack;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;

    logic        any_req;
    logic        pick_m1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    logic        out_of_window;

    // Arbitration: pick the winner among current requests and mux its transaction.
    always_comb begin
        any_req = iM0_REQ | iM1_REQ;
        if (iM0_REQ && iM1_REQ) begin
            // Tie: round-robin hands it to whoever was not granted last,
            // fixed priority always favours requester 0.
            pick_m1 = (ARB_MODE == 0) ? ~last_gnt : 1'b0;
        end else begin
            pick_m1 = iM1_REQ;
        end
        sel_we    = pick_m1 ? iM1_WE    : iM0_WE;
        sel_addr  = pick_m1 ? iM1_ADDR  : iM0_ADDR;
        sel_wdata = pick_m1 ? iM1_WDATA : iM0_WDATA;
    end

    // Window/alignment test on the selected address; 33 bits so the window end cannot wrap.
    always_comb begin
        win_lo        = {1'b0, RAM_ORIGIN};
        win_hi        = {1'b0, RAM_ORIGIN} + {1'b0, RAM_LENGTH};
        out_of_window = ({1'b0, sel_addr} < win_lo) ||
                        ({1'b0, sel_addr} >= win_hi) ||
                        (sel_addr[1:0] != 2'b00);
    end

`ifdef RAM_ARB_RANGE_CHECK_EN
    assign sel_bad = out_of_window;
`else
    // Check disabled: every access is forwarded and ERR stays 0. The window
    // terms remain elaborated so both builds share one parameter set.
    assign sel_bad = out_of_window & 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
        if (!iRAM_RST) begin
            state     <= ST_IDLE;
            last_gnt  <= 1'b1;
            lat_bad   <= 1'b0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            ram_ce    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_ACCESS;
                        busy      <= 1'b1;
                        gnt       <= pick_m1 ? 2'b10 : 2'b01;
                        last_gnt  <= pick_m1;
                        lat_bad   <= sel_bad;
                        ram_ce    <= ~sel_bad;
                        ram_rd    <= ~sel_bad & ~sel_we;
                        ram_wr    <= ~sel_bad & sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_we ? sel_wdata : '0;
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_DONE;
                    ram_ce    <= 1'b0;
                    ram_rd    <= 1'b0;
                    ram_wr    <= 1'b0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    // A transaction that did not read the RAM (write or rejected
                    // address) returns 0 on RDATA.
                    if (gnt[0]) begin
                        m0_ack   <= 1'b1;
                        m0_err   <= lat_bad;
                        m0_rdata <= ram_rd ? iRAM_RDATA : '0;
                    end
                    if (gnt[1]) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= lat_bad;
                        m1_rdata <= ram_rd ? iRAM_RDATA : '0;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    gnt     <= 2'b00;
                    lat_bad <= 1'b0;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_err  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oM0_ACK    = m0_ack;
    assign oM0_RDATA  = m0_rdata;
    assign oM0_ERR    = m0_err;
    assign oM1_ACK    = m1_ack;
    assign oM1_RDATA  = m1_rdata;
    assign oM1_ERR    = m1_err;
    assign oRAM_CE    = ram_ce;
    assign oRAM_RD    = ram_rd;
    assign oRAM_WR    = ram_wr;
    assign oRAM_ADDR  = ram_addr;
    assign oRAM_WDATA = ram_wdata;
    assign oGNT       = gnt;
    assign oBUSY      = busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. Instance "a" runs
// round-robin, instance "b" fixed priority; each has its own RAM model.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
    logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_ce, a_rd, a_wr, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_gnt;

    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_ce, b_rd, b_wr, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_gnt;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    ram_arbiter #(.ARB_MODE(0)) dut_rr (
        .iRAM_CLK(clk), .iRAM_RST(rst_n),
        .iM0_REQ(a_m0_req), .iM0_WE(a_m0_we), .iM0_ADDR(a_m0_addr), .iM0_WDATA(a_m0_wdata),
        .oM0_ACK(a_m0_ack), .oM0_RDATA(a_m0_rdata), .oM0_ERR(a_m0_err),
        .iM1_REQ(a_m1_req), .iM1_WE(a_m1_we), .iM1_ADDR(a_m1_addr), .iM1_WDATA(a_m1_wdata),
        .oM1_ACK(a_m1_ack), .oM1_RDATA(a_m1_rdata), .oM1_ERR(a_m1_err),
        .oRAM_CE(a_ce), .oRAM_RD(a_rd), .oRAM_WR(a_wr), .oRAM_ADDR(a_addr),
        .oRAM_WDATA(a_wdata), .iRAM_RDATA(a_rdata), .oGNT(a_gnt), .oBUSY(a_busy)
    );

    ram_arbiter #(.ARB_MODE(1)) dut_fp (
        .iRAM_CLK(clk), .iRAM_RST(rst_n),
        .iM0_REQ(b_m0_req), .iM0_WE(b_m0_we), .iM0_ADDR(b_m0_addr), .iM0_WDATA(b_m0_wdata),
        .oM0_ACK(b_m0_ack), .oM0_RDATA(b_m0_rdata), .oM0_ERR(b_m0_err),
        .iM1_REQ(b_m1_req), .iM1_WE(b_m1_we), .iM1_ADDR(b_m1_addr), .iM1_WDATA(b_m1_wdata),
        .oM1_ACK(b_m1_ack), .oM1_RDATA(b_m1_rdata), .oM1_ERR(b_m1_err),
        .oRAM_CE(b_ce), .oRAM_RD(b_rd), .oRAM_WR(b_wr), .oRAM_ADDR(b_addr),
        .oRAM_WDATA(b_wdata), .iRAM_RDATA(b_rdata), .oGNT(b_gnt), .oBUSY(b_busy)
    );

    // RAM models: combinational read, write committed on the clock edge.
    assign a_rdata = mem_a[a_addr[9:2]];
    assign b_rdata = mem_b[b_addr[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            mem_b[8'h41] <= 32'h0000_0A0A;
            mem_b[8'h42] <= 32'h0000_0B0B;
        end else begin
            if (a_ce && a_wr) mem_a[a_addr[9:2]] <= a_wdata;
            if (b_ce && b_wr) mem_b[b_addr[9:2]] <= b_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic who, input logic [31:0] rd, input logic err);
        exp_t e;
        e.who = who; e.rdata = rd; e.err = err;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic who, input logic [31:0] rd, input logic err);
        exp_t e;
        e.who = who; e.rdata = rd; e.err = err;
        qb.push_back(e);
    endtask

    task automatic pop_check(input bit is_b, input logic ack0, input logic ack1,
                             input logic [31:0] rd0, input logic [31:0] rd1,
                             input logic er0, input logic er1);
        exp_t  e;
        string tag;
        tag = is_b ? "fp" : "rr";
        if (!ack0 && !ack1) return;
        checks++;
        if (ack0 && ack1) begin
            failures++;
            $display("FAIL %s_both_ack actual=11 required=one-hot", tag);
            return;
        end
        if ((is_b && qb.size() == 0) || (!is_b && qa.size() == 0)) begin
            failures++;
            $display("FAIL %s_unexpected_ack actual=ack0:%b ack1:%b required=no ack", tag, ack0, ack1);
            return;
        end
        failures = failures;
        e = is_b ? qb.pop_front() : qa.pop_front();
        chk({tag, "_ack_who"}, {31'b0, ack1}, {31'b0, e.who});
        chk({tag, "_rdata"}, ack1 ? rd1 : rd0, e.rdata);
        chk({tag, "_err"}, {31'b0, ack1 ? er1 : er0}, {31'b0, e.err});
    endtask

    // Monitors: compare every ACK against the head of the matching queue.
    always @(negedge clk) if (rst_n) pop_check(1'b0, a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata, a_m0_err, a_m1_err);
    always @(negedge clk) if (rst_n) pop_check(1'b1, b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_m0_err, b_m1_err);

    // Single transaction on instance a with pin and latency checks.
    task automatic xfer(input logic who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic exp_fwd, input string name);
        push_a(who, exp_rd, exp_err);
        @(negedge clk);
        if (!who) begin
            a_m0_req = 1'b1; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd;
        end else begin
            a_m1_req = 1'b1; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd;
        end
        @(negedge clk);
        chk({name, "_ce"}, {31'b0, a_ce}, {31'b0, exp_fwd});
        chk({name, "_rd"}, {31'b0, a_rd}, {31'b0, exp_fwd & ~we});
        chk({name, "_wr"}, {31'b0, a_wr}, {31'b0, exp_fwd & we});
        chk({name, "_gnt"}, {30'b0, a_gnt}, who ? 32'd2 : 32'd1);
        chk({name, "_busy_access"}, {31'b0, a_busy}, 32'd1);
        if (exp_fwd) chk({name, "_addr"}, a_addr, addr);
        if (exp_fwd && we) chk({name, "_wdata"}, a_wdata, wd);
        @(negedge clk);
        chk({name, "_ack_latency"}, {31'b0, who ? a_m1_ack : a_m0_ack}, 32'd1);
        chk({name, "_other_ack"}, {31'b0, who ? a_m0_ack : a_m1_ack}, 32'd0);
        chk({name, "_ce_done"}, {31'b0, a_ce | a_rd | a_wr}, 32'd0);
        if (!who) a_m0_req = 1'b0; else a_m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        int n0;
        a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;

        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_rr_ctrl", {23'b0, a_ce, a_rd, a_wr, a_busy, a_gnt, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 32'd0);
        chk("rst_rr_data", a_addr | a_wdata | a_m0_rdata | a_m1_rdata, 32'd0);
        chk("rst_fp_ctrl", {23'b0, b_ce, b_rd, b_wr, b_busy, b_gnt, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err}, 32'd0);
        rst_n = 1'b1;

        xfer(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, "m0_wr");
        xfer(1'b0, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, "m0_rd");
        xfer(1'b1, 1'b1, 32'h108, 32'hCAFE_0001, 32'h0, 1'b0, 1'b1, "m1_wr");
`ifdef RAM_ARB_RANGE_CHECK_EN
        xfer(1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 1'b1, 1'b0, "m1_rd_oob");
`else
        xfer(1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 1'b1, "m1_rd_oob");
`endif

        // Round-robin with both requesting: M0, M1, M0, M1 every 3 cycles.
        push_a(1'b0, 32'hDEAD_BEEF, 1'b0);
        push_a(1'b1, 32'hCAFE_0001, 1'b0);
        push_a(1'b0, 32'hDEAD_BEEF, 1'b0);
        push_a(1'b1, 32'hCAFE_0001, 1'b0);
        @(negedge clk);
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h104;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h108;
        n = 0; last = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (a_m0_ack || a_m1_ack) begin
                if (n > 0) chk("rr_ack_spacing", cycle - last, 32'd3);
                last = cycle;
                n++;
            end
        end
        a_m0_req = 0; a_m1_req = 0;
        chk("rr_ack_count", n, 32'd4);

        // Reset during ACCESS of an M1 write: aborted, no ACK, next tie to M0.
        xfer(1'b0, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, "m0_rd2");
        @(negedge clk);
        a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h10C; a_m1_wdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("rst_pre_wr", {31'b0, a_wr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {23'b0, a_ce, a_rd, a_wr, a_busy, a_gnt, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 32'd0);
        chk("rst_mid_data", a_addr | a_wdata | a_m0_rdata | a_m1_rdata, 32'd0);
        a_m1_req = 0; a_m1_we = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_ack", {31'b0, a_m0_ack | a_m1_ack}, 32'd0);
        end
        push_a(1'b0, 32'hDEAD_BEEF, 1'b0);
        push_a(1'b1, 32'h0, 1'b0);
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h104;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h10C;
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(negedge clk);
            if (a_m0_ack) begin a_m0_req = 0; n++; end
            if (a_m1_ack) begin a_m1_req = 0; n++; end
        end
        a_m0_req = 0; a_m1_req = 0;
        chk("post_rst_ack_count", n, 32'd2);

        // Fixed priority: M0 wins until it drops REQ, then M1.
        push_b(1'b0, 32'h0000_0A0A, 1'b0);
        push_b(1'b0, 32'h0000_0A0A, 1'b0);
        push_b(1'b0, 32'h0000_0A0A, 1'b0);
        push_b(1'b1, 32'h0000_0B0B, 1'b0);
        @(negedge clk);
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h104;
        b_m1_req = 1; b_m1_we = 0; b_m1_addr = 32'h108;
        n = 0; n0 = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (b_m0_ack) begin
                n0++; n++;
                if (n0 == 3) b_m0_req = 0;
            end
            if (b_m1_ack) begin
                b_m1_req = 0; n++;
            end
        end
        b_m0_req = 0; b_m1_req = 0;
        chk("fp_ack_count", n, 32'd4);

        repeat (4) @(negedge clk);
        chk("rr_queue_drained", qa.size(), 32'd0);
        chk("fp_queue_drained", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
